// File: rtl/contador_param.sv
// rtl/contador_param.sv - parametrised up/down/step/load counter with modulus wrap and cascade carry

module contador_param #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16,
   parameter int STEP    = 3
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ENB,
   input  logic             RCI,
   input  logic [1:0]       MODO,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             RCO
);

   // One extra bit keeps Q+MODULUS-STEP and the D>=MODULUS compare exact
   // even when MODULUS == 2**WIDTH.
   localparam logic [WIDTH:0] MOD_W  = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH:0] MAX_W  = (WIDTH+1)'(MODULUS - 1);
   localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);

   logic [WIDTH-1:0] q_q, q_d;
   logic             rco_q, rco_d;
   logic [WIDTH:0]   q_ext, d_ext, nxt_ext;

   // Next count and wrap flag; an idle cycle holds Q and drops RCO.
   always_comb begin
      q_ext   = {1'b0, q_q};
      d_ext   = {1'b0, D};
      nxt_ext = q_ext;
      rco_d   = 1'b0;
      if (ENB && RCI) begin
         case (MODO)
            2'b00: begin
               if (q_ext == MAX_W) begin
                  nxt_ext = '0;
                  rco_d   = 1'b1;
               end else begin
                  nxt_ext = q_ext + 1'b1;
               end
            end
            2'b01: begin
               if (q_ext == '0) begin
                  nxt_ext = MAX_W;
                  rco_d   = 1'b1;
               end else begin
                  nxt_ext = q_ext - 1'b1;
               end
            end
            2'b10: begin
               if (q_ext < STEP_W) begin
                  nxt_ext = q_ext + MOD_W - STEP_W;
                  rco_d   = 1'b1;
               end else begin
                  nxt_ext = q_ext - STEP_W;
               end
            end
            default: begin
               // Out-of-range loads saturate so Q never leaves 0..MODULUS-1.
               nxt_ext = (d_ext < MOD_W) ? d_ext : MAX_W;
            end
         endcase
      end
      q_d = WIDTH'(nxt_ext);
   end

   // Count and carry registers with synchronous reset taking priority.
   always_ff @(posedge CLK) begin
      if (RST) begin
         q_q   <= '0;
         rco_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         rco_q <= rco_d;
      end
   end

   assign Q   = q_q;
   assign RCO = rco_q;

endmodule

// File: tb/tb_contador_param.sv
// tb/tb_contador_param.sv - scoreboard bench for contador_param with directed vectors

module tb_contador_param;

   typedef struct {
      int         id;
      logic [3:0] q;
      logic       rco;
      string      tag;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // id 0: defaults (mod 16)
   logic       rst_a, enb_a, rci_a;
   logic [1:0] modo_a;
   logic [3:0] d_a, q_a;
   logic       rco_a;
   // id 1: modulus 10
   logic       rst_b, enb_b, rci_b;
   logic [1:0] modo_b;
   logic [3:0] d_b, q_b;
   logic       rco_b;
   // id 2/3: two-stage cascade, modulus 10
   logic       rst_c, enb_c;
   logic [1:0] modo_c;
   logic [3:0] d_c, q_lo, q_hi;
   logic       rco_lo, rco_hi;
   // id 4: modulus 3, step 2, width 2
   logic       rst_m, enb_m, rci_m;
   logic [1:0] modo_m, d_m, q_m;
   logic       rco_m;

   contador_param #(.WIDTH(4), .MODULUS(16), .STEP(3)) u_a (
      .CLK(clk), .RST(rst_a), .ENB(enb_a), .RCI(rci_a), .MODO(modo_a),
      .D(d_a), .Q(q_a), .RCO(rco_a));
   contador_param #(.WIDTH(4), .MODULUS(10), .STEP(3)) u_b (
      .CLK(clk), .RST(rst_b), .ENB(enb_b), .RCI(rci_b), .MODO(modo_b),
      .D(d_b), .Q(q_b), .RCO(rco_b));
   contador_param #(.WIDTH(4), .MODULUS(10), .STEP(3)) u_lo (
      .CLK(clk), .RST(rst_c), .ENB(enb_c), .RCI(1'b1), .MODO(modo_c),
      .D(d_c), .Q(q_lo), .RCO(rco_lo));
   contador_param #(.WIDTH(4), .MODULUS(10), .STEP(3)) u_hi (
      .CLK(clk), .RST(rst_c), .ENB(enb_c), .RCI(rco_lo), .MODO(modo_c),
      .D(d_c), .Q(q_hi), .RCO(rco_hi));
   contador_param #(.WIDTH(2), .MODULUS(3), .STEP(2)) u_m (
      .CLK(clk), .RST(rst_m), .ENB(enb_m), .RCI(rci_m), .MODO(modo_m),
      .D(d_m), .Q(q_m), .RCO(rco_m));

   exp_t  sb[$];
   string tag;
   int    n_checks = 0;
   int    n_fail   = 0;
   string names[5] = '{"mod16", "mod10", "casc_lo", "casc_hi", "mod3"};

   task automatic expect_q(input int id, input int q, input logic rco);
      exp_t e;
      e.id  = id;
      e.q   = 4'(q);
      e.rco = rco;
      e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Monitor: after each rising edge, retire every expectation issued for it.
   exp_t       e_mon;
   logic [3:0] act_q;
   logic       act_r;
   always begin
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e_mon = sb.pop_front();
         case (e_mon.id)
            0:       begin act_q = q_a;          act_r = rco_a;  end
            1:       begin act_q = q_b;          act_r = rco_b;  end
            2:       begin act_q = q_lo;         act_r = rco_lo; end
            3:       begin act_q = q_hi;         act_r = rco_hi; end
            default: begin act_q = {2'b00, q_m}; act_r = rco_m;  end
         endcase
         n_checks++;
         if (act_q !== e_mon.q || act_r !== e_mon.rco) begin
            n_fail++;
            $display("FAIL %s %s @%0t: Q=%0d RCO=%0b, expected Q=%0d RCO=%0b",
                     e_mon.tag, names[e_mon.id], $time, act_q, act_r, e_mon.q, e_mon.rco);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      rst_a = 1; enb_a = 0; rci_a = 1; modo_a = 0; d_a = 0;
      rst_b = 1; enb_b = 0; rci_b = 1; modo_b = 0; d_b = 0;
      rst_c = 1; enb_c = 0; modo_c = 0; d_c = 0;
      rst_m = 1; enb_m = 0; rci_m = 1; modo_m = 0; d_m = 0;

      tag = "reset";
      for (int i = 0; i < 5; i++) expect_q(i, 0, 0);
      tick();
      rst_a = 0; rst_b = 0; rst_c = 0; rst_m = 0;

      // Reset overrides an enabled count from 9
      tag = "t1_load9"; enb_a = 1; modo_a = 2'b11; d_a = 9; expect_q(0, 9, 0); tick();
      tag = "t1_rst";   rst_a = 1; modo_a = 2'b00;          expect_q(0, 0, 0); tick();
      rst_a = 0;

      // Full up cycle, wrap pulse on the edge that shows 0
      tag = "t2_up16";
      for (int i = 1; i <= 16; i++) begin
         expect_q(0, i % 16, i == 16);
         tick();
      end

      // Advance gating: ENB=0 or RCI=0 holds Q, blocks load, drops RCO
      tag = "hold_enb"; enb_a = 0; expect_q(0, 0, 0); tick();
      tag = "hold_rci"; enb_a = 1; rci_a = 0; modo_a = 2'b11; d_a = 5; expect_q(0, 0, 0); tick();
      tag = "load_adv"; rci_a = 1; expect_q(0, 5, 0); tick();

      // Step-down by 3 from 7
      tag = "t4_step"; d_a = 7; expect_q(0, 7, 0); tick();
      modo_a = 2'b10;
      expect_q(0, 4, 0);  tick();
      expect_q(0, 1, 0);  tick();
      expect_q(0, 14, 1); tick();
      expect_q(0, 11, 0); tick();

      // Down wrap, then a mode change taking effect on the next edge
      tag = "down16"; modo_a = 2'b11; d_a = 0; expect_q(0, 0, 0); tick();
      modo_a = 2'b01; expect_q(0, 15, 1); tick();
      expect_q(0, 14, 0); tick();
      tag = "modo_chg"; modo_a = 2'b00; expect_q(0, 15, 0); tick();
      expect_q(0, 0, 1); tick();

      // Reset wins over a pending wrap
      tag = "rst_wrap"; modo_a = 2'b11; d_a = 15; expect_q(0, 15, 0); tick();
      rst_a = 1; modo_a = 2'b00; expect_q(0, 0, 0); tick();
      rst_a = 0; enb_a = 0;

      // Modulus 10: down wrap, load saturation, hold, up wrap, step wrap
      tag = "t3_down10"; enb_b = 1; modo_b = 2'b01; expect_q(1, 9, 1); tick();
      expect_q(1, 8, 0); tick();
      tag = "t5_load6";  modo_b = 2'b11; d_b = 6;  expect_q(1, 6, 0); tick();
      tag = "t5_load12"; d_b = 12; expect_q(1, 9, 0); tick();
      tag = "load10";    d_b = 10; expect_q(1, 9, 0); tick();
      tag = "t5_hold";   enb_b = 0; d_b = 3; expect_q(1, 9, 0); tick();
      tag = "up10_wrap"; enb_b = 1; modo_b = 2'b00; expect_q(1, 0, 1); tick();
      tag = "step10";    modo_b = 2'b11; d_b = 1; expect_q(1, 1, 0); tick();
      modo_b = 2'b10; expect_q(1, 8, 1); tick();
      expect_q(1, 5, 0); tick();
      enb_b = 0;

      // Modulus 3, step 2: consecutive wrap pulses, saturation, up wrap
      tag = "mod3_step"; enb_m = 1; modo_m = 2'b10;
      expect_q(4, 1, 1); tick();
      expect_q(4, 2, 1); tick();
      expect_q(4, 0, 0); tick();
      expect_q(4, 1, 1); tick();
      tag = "mod3_sat"; modo_m = 2'b11; d_m = 3; expect_q(4, 2, 0); tick();
      tag = "mod3_up";  modo_m = 2'b00; expect_q(4, 0, 1); tick();
      enb_m = 0;

      // Cascade: upper stage advances one edge after lower wraps
      tag = "t6_cascade"; enb_c = 1; modo_c = 2'b00;
      for (int i = 1; i <= 14; i++) begin
         expect_q(2, i % 10, i == 10);
         expect_q(3, (i >= 11) ? 1 : 0, 0);
         tick();
      end
      tag = "t6_rst"; rst_c = 1;
      expect_q(2, 0, 0);
      expect_q(3, 0, 0);
      tick();
      rst_c = 0; enb_c = 0;
      tick();

      tag = "drain";
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
